// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program sequencer.
package td4_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned INSTR_W  = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/td4_prog_mem.sv
// Program store: register file cleared by reset, one sync write port, one async read port.
module td4_prog_mem
  import td4_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= NOP_INSTR;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/td4_sequencer.sv
// TD4 program sequencer: run/step/halt FSM, CPU clock-enable gating, program store, exec counter.
// Optional breakpoint logic is enabled by defining TD4_SEQ_BREAKPOINT_EN.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [3:0]          load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                run,
  input  logic                step,
  input  logic                halt,
  input  logic [3:0]          pc_in,
  output logic [OPCODE_W-1:0] opcode,
  output logic [IMM_W-1:0]    immediate,
  output logic                cpu_ce,
  output logic                running,
  output logic [CNT_W-1:0]    exec_count,
  input  logic                bp_en,
  input  logic [3:0]          bp_addr,
  output logic                bp_hit
);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brk;
  logic               cmd_accept;
  logic [INSTR_W-1:0] rdata;

`ifdef TD4_SEQ_BREAKPOINT_EN
  logic first_q, first_d;
  logic bp_hit_q, bp_hit_d;

  // The first RUN cycle after entry is exempt so resuming executes the breakpoint word.
  assign brk = (state_q == RUN) && bp_en && (pc_in == bp_addr) && !first_q;

  always_comb begin
    first_d  = (state_q != RUN);
    bp_hit_d = cmd_accept ? 1'b0 : (bp_hit_q | brk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      first_q  <= first_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign brk       = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign load_ready = (state_q == IDLE) || (state_q == HALTED);
  assign running    = (state_q == RUN) || (state_q == STEP);
  assign cmd_accept = load_ready && !halt && (step || run);
  assign cpu_ce     = ((state_q == RUN) && !halt && !brk) || (state_q == STEP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (!halt) begin
          if (step)     state_d = STEP;
          else if (run) state_d = RUN;
        end
      end
      RUN:     if (halt || brk) state_d = HALTED;
      STEP:    state_d = HALTED;
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (cpu_ce && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exec_count = cnt_q;

  td4_prog_mem #(
    .DEPTH (PROG_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (load_valid && load_ready),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_in),
    .rdata (rdata)
  );

  assign {opcode, immediate} = cpu_ce ? rdata : NOP_INSTR;

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed self-checking bench for td4_sequencer (breakpoint checks follow TD4_SEQ_BREAKPOINT_EN).
module tb_td4_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       run;
  logic       step;
  logic       halt;
  logic [3:0] pc_in;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       cpu_ce;
  logic       running;
  logic [7:0] exec_count;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic       bp_hit;

  int n_checks = 0;
  int n_errors = 0;

  td4_sequencer #(
    .PROG_DEPTH (16),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .run        (run),
    .step       (step),
    .halt       (halt),
    .pc_in      (pc_in),
    .opcode     (opcode),
    .immediate  (immediate),
    .cpu_ce     (cpu_ce),
    .running    (running),
    .exec_count (exec_count),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    run = 1'b0; step = 1'b0; halt = 1'b0; pc_in = '0; bp_en = 1'b0; bp_addr = '0;

    #2;
    check_eq("rst_ce", cpu_ce, 0);
    check_eq("rst_ready", load_ready, 1);
    check_eq("rst_cnt", exec_count, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_bp_hit", bp_hit, 0);
    tick(); tick();
    rst_n = 1'b1;

    repeat (5) tick();
    check_eq("idle_ce", cpu_ce, 0);
    check_eq("idle_op", opcode, 0);
    check_eq("idle_imm", immediate, 0);
    check_eq("idle_ready", load_ready, 1);
    check_eq("idle_cnt", exec_count, 0);

    load_valid = 1'b1; load_addr = 4'd0; load_data = 8'hC3;
    tick();
    load_addr = 4'd1; load_data = 8'h02;
    tick();
    load_valid = 1'b0;

    run = 1'b1; pc_in = 4'd0;
    #1 check_eq("pre_run_ce", cpu_ce, 0);
    tick();
    run = 1'b0;
    load_valid = 1'b1; load_addr = 4'd0; load_data = 8'hFF;
    #1;
    check_eq("run_ce", cpu_ce, 1);
    check_eq("run_op", opcode, 4'hC);
    check_eq("run_imm", immediate, 4'h3);
    check_eq("run_running", running, 1);
    check_eq("run_ready", load_ready, 0);

`ifndef TD4_SEQ_BREAKPOINT_EN
    bp_en = 1'b1; bp_addr = 4'd1;
`endif
    for (int i = 0; i < 10; i++) begin
      pc_in = 4'(i % 2);
      #1;
      check_eq("loop_ce", cpu_ce, 1);
      check_eq("loop_op", opcode, (i % 2) ? 4'h0 : 4'hC);
      check_eq("loop_imm", immediate, (i % 2) ? 4'h2 : 4'h3);
      check_eq("loop_cnt", exec_count, i);
      tick();
    end
    check_eq("loop_bp_hit", bp_hit, 0);
    bp_en = 1'b0;

    halt = 1'b1;
    #1;
    check_eq("halt_ce", cpu_ce, 0);
    check_eq("halt_op", opcode, 0);
    check_eq("halt_cnt", exec_count, 10);
    tick();
    halt = 1'b0; load_valid = 1'b0;
    #1;
    check_eq("halted_running", running, 0);
    check_eq("halted_ready", load_ready, 1);
    check_eq("halted_ce", cpu_ce, 0);
    check_eq("halted_cnt", exec_count, 10);

    pc_in = 4'd0; step = 1'b1; run = 1'b1;
    #1 check_eq("stepcmd_ce", cpu_ce, 0);
    tick();
    step = 1'b0; run = 1'b0;
    #1;
    check_eq("step_ce", cpu_ce, 1);
    check_eq("step_op_no_overwrite", opcode, 4'hC);
    check_eq("step_imm", immediate, 4'h3);
    check_eq("step_running", running, 1);
    tick();
    check_eq("post_step_ce", cpu_ce, 0);
    check_eq("post_step_running", running, 0);
    check_eq("post_step_cnt", exec_count, 11);
    check_eq("post_step_ready", load_ready, 1);
    tick();
    check_eq("post_step2_ce", cpu_ce, 0);
    check_eq("post_step2_cnt", exec_count, 11);

    run = 1'b1;
    tick();
    run = 1'b0;
    #1 check_eq("prerst_ce", cpu_ce, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ce", cpu_ce, 0);
    check_eq("async_rst_cnt", exec_count, 0);
    check_eq("async_rst_running", running, 0);
    check_eq("async_rst_ready", load_ready, 1);
    tick();
    rst_n = 1'b1;

    halt = 1'b1; run = 1'b1;
    tick();
    check_eq("haltrun_ce", cpu_ce, 0);
    check_eq("haltrun_running", running, 0);
    halt = 1'b0; run = 1'b0;
    #1 check_eq("haltrun_ce2", cpu_ce, 0);

    step = 1'b1; pc_in = 4'd0;
    tick();
    step = 1'b0;
    #1;
    check_eq("clr_ce", cpu_ce, 1);
    check_eq("clr_op", opcode, 0);
    check_eq("clr_imm", immediate, 0);
    tick();

    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (300) tick();
    check_eq("sat_cnt", exec_count, 255);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("sat_halt_cnt", exec_count, 255);

`ifdef TD4_SEQ_BREAKPOINT_EN
    begin
      logic [3:0] pc;
      logic       ce_s;
      logic       stopped;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bp_en = 1'b1; bp_addr = 4'd5; pc = 4'd0; pc_in = 4'd0; stopped = 1'b0;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 0; k < 20 && !stopped; k++) begin
        pc_in = pc;
        #1;
        ce_s = cpu_ce;
        if (pc == 4'd5) begin
          check_eq("bp_ce", ce_s, 0);
          tick();
          check_eq("bp_hit_set", bp_hit, 1);
          check_eq("bp_running", running, 0);
          stopped = 1'b1;
        end else begin
          check_eq("bp_pre_ce", ce_s, 1);
          tick();
          if (ce_s) pc = pc + 4'd1;
        end
      end
      check_eq("bp_reached", stopped, 1);
      run = 1'b1;
      tick();
      run = 1'b0;
      pc_in = 4'd5;
      #1;
      check_eq("bp_resume_ce", cpu_ce, 1);
      check_eq("bp_resume_clear", bp_hit, 0);
      check_eq("bp_resume_running", running, 1);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      bp_en = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Program sequencer for the 4-bit TD4 CPU core. It holds the 16-word program store and loads it over a valid/ready write port. It drives `opcode`/`immediate` from the CPU's program counter and gates execution with a one-bit clock enable under a run/step/halt state machine. It sits between the host-facing pins and the CPU core; the CPU advances its state (including `pc`) only on edges where `cpu_ce` is high.

## Interface
Parameters:
- `PROG_DEPTH`, 16: program words; fixed to 2^4 to match the 4-bit program counter.
- `CNT_W`, 8: width of the executed-instruction counter.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  program-write request.
- `load_ready`  out  1  store accepts a write this cycle.
- `load_addr`  in  4  program word address.
- `load_data`  in  8  instruction word; [7:4] is the opcode, [3:0] is the immediate.
- `run`  in  1  start or resume continuous execution (level, sampled each cycle).
- `step`  in  1  execute exactly one instruction.
- `halt`  in  1  stop execution.
- `pc_in`  in  4  program counter from the CPU.
- `opcode`  out  4  instruction opcode to the CPU.
- `immediate`  out  4  instruction immediate to the CPU.
- `cpu_ce`  out  1  CPU clock enable.
- `running`  out  1  state is RUN or STEP.
- `exec_count`  out  CNT_W  count of cycles with `cpu_ce` high; saturating.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  4  breakpoint address.
- `bp_hit`  out  1  sticky flag: halted on a breakpoint.

## Operation
- States: IDLE (reset state), RUN, STEP, HALTED.
- Command priority within a cycle: `halt` > `step` > `run`.
- IDLE and HALTED transitions:
  - `step` goes to STEP.
  - `run` goes to RUN.
  - `halt` keeps the current state.
- RUN transitions:
  - `halt` goes to HALTED.
  - `step` and `run` are ignored.
- STEP: unconditionally goes to HALTED after one cycle.
- `cpu_ce` = (RUN && !`halt` && !break) || STEP. This is combinational from the state register and the `halt` input.
- `opcode`/`immediate` = mem[`pc_in`] when `cpu_ce` is high; otherwise 4'h0/4'h0. This is combinational, an asynchronous read; 0x00 is ADD A,0, which is harmless.
- Program writes:
  - `load_ready` = (state is IDLE or HALTED).
  - mem[`load_addr`] <= `load_data` when `load_valid && load_ready`.
  - A write in the same cycle as `run`/`step` still completes, so the first executed instruction observes the new data.
- `exec_count`:
  - Increments on each edge with `cpu_ce` high.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- `pc_in` wrap (15 to 0) is the CPU's business; the sequencer indexes the store modulo 16 with no special case.

## Timing
- Reset values:
  - State IDLE.
  - All 16 memory words 0x00.
  - `cpu_ce`, `opcode`, `immediate`, `running`, `bp_hit` all 0.
  - `exec_count` 0.
  - `load_ready` 1.
- `run` sampled high at edge N: state is RUN from N. `cpu_ce` is high in the cycle after edge N, and the CPU executes mem[`pc_in`] at edge N+1.
- `halt` high in cycle M while in RUN:
  - `cpu_ce` is low in cycle M (zero-latency stop).
  - State is HALTED after edge M.
  - No instruction executes in cycle M.
- `step`: `cpu_ce` is high for exactly one cycle, and exactly one instruction executes.
- Reset mid-RUN: the store is cleared and the sequencer returns to IDLE asynchronously. `cpu_ce` drops immediately.

## Configuration
- Macro `TD4_SEQ_BREAKPOINT_EN`.
- Defined:
  - In RUN, if `bp_en && pc_in == bp_addr` and this is not the first RUN cycle after entry, then `cpu_ce` is low that cycle, state goes to HALTED, and `bp_hit` is set.
  - `bp_hit` clears on the edge that accepts `run` or `step`.
  - Resuming from a breakpoint therefore executes the breakpoint instruction.
  - STEP ignores breakpoints.
- Undefined:
  - `bp_en`/`bp_addr` are ignored and `bp_hit` is tied 0.
  - Port list is unchanged.

## Structure
- Package `td4_pkg` holds:
  - The state enum `seq_state_t` {IDLE, RUN, STEP, HALTED}.
  - `OPCODE_W`=4, `IMM_W`=4, `INSTR_W`=8.
  - The NOP instruction word 8'h00.
- Sub-module `td4_prog_mem`: 16×8 register file with async reset clear, one synchronous write port and one asynchronous read port.
- FSM, gating and counter live in `td4_sequencer`.

## Test plan
- Reset, then idle 5 cycles:
  - `cpu_ce`=0, `opcode`/`immediate`=0, `load_ready`=1, `exec_count`=0.
- Load addr0=0xC3 and addr1=0x02, then pulse `run` with `pc_in`=0:
  - Next cycle, `opcode`=0xC, `immediate`=0x3, `cpu_ce`=1.
  - During RUN, `load_ready`=0 and a write to addr0 is not accepted.
- RUN for 10 cycles, then `halt`:
  - `cpu_ce` is low in the `halt` cycle; state is HALTED.
  - `exec_count`=10.
- From HALTED, assert `step` and `run` in the same cycle:
  - Exactly one cycle with `cpu_ce`=1, then HALTED.
- `halt`+`run` together from IDLE: remains IDLE and `cpu_ce` stays 0.
- With `TD4_SEQ_BREAKPOINT_EN`, `bp_en`=1, `bp_addr`=5, run from `pc_in`=0:
  - Halts with `cpu_ce`=0 while `pc_in`=5, and `bp_hit`=1.
  - A subsequent `run` executes pc 5 and clears `bp_hit`.
